// File: rtl/user_slv_pkg.sv
// Shared definitions for the user-slot bus responder: register word offsets,
// CTRL bit positions, bus FSM states and a byte-lane merge helper.
package user_slv_pkg;

  localparam logic [31:0] USLV_ID = 32'h5553_4C56;

  // Word offsets, i.e. mem_addr_i[7:2]
  localparam logic [5:0] OFF_ID   = 6'h00;
  localparam logic [5:0] OFF_CTRL = 6'h01;
  localparam logic [5:0] OFF_STAT = 6'h02;
  localparam logic [5:0] OFF_CMP  = 6'h03;
  localparam logic [5:0] OFF_CNT  = 6'h04;
  localparam logic [5:0] OFF_SCR  = 6'h05;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_AR  = 2;
  localparam int CTRL_CLR = 3;

  localparam int RAM_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } bus_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_slv_timer.sv
// Free-running compare timer: CNT counts while enabled, EXP latches on a
// CNT==CMP match, and the match either reloads CNT or tells the owner to stop.
module user_slv_timer
  import user_slv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        ar_i,
  input  logic        clr_i,
  input  logic        cmp_we_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  input  logic        exp_clr_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic        exp_o,
  output logic        expire_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        exp_q, exp_d;
  logic        hit;

  assign hit = en_i && (cnt_q == cmp_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = ar_i ? 32'd0 : cnt_q;
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end
    cmp_d = cmp_we_i ? byte_merge(cmp_q, wdata_i, wstrb_i) : cmp_q;
    // A hardware expiry beats a same-cycle write-1-to-clear
    exp_d = hit ? 1'b1 : (exp_clr_i ? 1'b0 : exp_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      cmp_q <= 32'hFFFF_FFFF;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      exp_q <= exp_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign cmp_o    = cmp_q;
  assign exp_o    = exp_q;
  assign expire_o = hit;

endmodule

// File: rtl/user_slv_design.sv
// User-slot native-bus responder: ID, CTRL/STAT, compare timer, SCR and a
// 16-word byte-writable scratch RAM behind a wait-state bus FSM.
module user_slv_design
  import user_slv_pkg::*;
#(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = USLV_ID
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        irq_o
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e  state_q;
  logic [3:0]  wcnt_q;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] scr_q, scr_d;
  logic        irq_q;

  logic [5:0]  word_sel;
  logic        ram_hit;
  logic [3:0]  ram_idx;
  logic        commit;
  logic        ctrl_wr;
  logic        timer_clr;
  logic        exp_clr;
  logic        cmp_we;
  logic [31:0] ram_rdata;
  logic [31:0] rd_mux;

  logic [31:0] cnt_val, cmp_val;
  logic        exp_val, expire;

  logic        unused_addr;
  assign unused_addr = ^{mem_addr_i[31:8], mem_addr_i[1:0]};

  assign word_sel  = mem_addr_i[7:2];
  assign ram_hit   = (word_sel[5:4] == 2'b01);
  assign ram_idx   = word_sel[3:0];
  assign commit    = (state_q == ST_RESP) && (mem_wstrb_i != 4'b0000);
  assign ctrl_wr   = commit && !ram_hit && (word_sel == OFF_CTRL) && mem_wstrb_i[0];
  assign timer_clr = ctrl_wr && mem_wdata_i[CTRL_CLR];
  assign exp_clr   = commit && (word_sel == OFF_STAT) && mem_wstrb_i[0] && mem_wdata_i[0];
  assign cmp_we    = commit && (word_sel == OFF_CMP);

  user_slv_timer u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (ctrl_q[CTRL_EN]),
    .ar_i      (ctrl_q[CTRL_AR]),
    .clr_i     (timer_clr),
    .cmp_we_i  (cmp_we),
    .wstrb_i   (mem_wstrb_i),
    .wdata_i   (mem_wdata_i),
    .exp_clr_i (exp_clr),
    .cnt_o     (cnt_val),
    .cmp_o     (cmp_val),
    .exp_o     (exp_val),
    .expire_o  (expire)
  );

  // Bus FSM; ready and read data are registered on the edge entering RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_valid_i) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              rdata_q <= rd_mux;
            end else begin
              state_q <= ST_WAIT;
              wcnt_q  <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!mem_valid_i) begin
            state_q <= ST_IDLE;
          end else if (wcnt_q == 4'd0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= rd_mux;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (ram_hit) begin
      rd_mux = ram_rdata;
    end else begin
      case (word_sel)
        OFF_ID:   rd_mux = ID_VALUE;
        OFF_CTRL: rd_mux = {29'd0, ctrl_q};
        OFF_STAT: rd_mux = {31'd0, exp_val};
        OFF_CMP:  rd_mux = cmp_val;
        OFF_CNT:  rd_mux = cnt_val;
        OFF_SCR:  rd_mux = scr_q;
        default:  rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (expire && !ctrl_q[CTRL_AR]) ctrl_d[CTRL_EN] = 1'b0;
    // Bus write lands after the hardware stop so software always wins
    if (ctrl_wr) ctrl_d = mem_wdata_i[2:0];
    scr_d = scr_q;
    if (commit && !ram_hit && (word_sel == OFF_SCR)) begin
      scr_d = byte_merge(scr_q, mem_wdata_i, mem_wstrb_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      scr_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      scr_q  <= scr_d;
      irq_q  <= exp_val && ctrl_q[CTRL_IE];
    end
  end

  // One RAM per byte lane; the read is captured by rdata_q entering RESP
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [RAM_WORDS];

    always_ff @(posedge clk_i) begin
      if (commit && ram_hit && mem_wstrb_i[gi]) begin
        mem_q[ram_idx] <= mem_wdata_i[gi*8 +: 8];
      end
    end

    assign ram_rdata[gi*8 +: 8] = mem_q[ram_idx];
  end

  assign mem_rdata_o = rdata_q;
  assign mem_ready_o = ready_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_user_slv_design.sv
// Scoreboard bench for user_slv_design: dut0 runs with one wait state,
// dut1 with three for the abort and mid-transaction reset scenarios.
module tb_user_slv_design;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
  } exp_t;

  logic        clk;
  logic        rst_s   [2];
  logic        valid_s [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  wstrb_s [2];

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic        irq0, irq1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int total = 0;
  int bad   = 0;
  int rdy1_cnt = 0;

  user_slv_design #(.WAIT_CYCLES(1), .ID_VALUE(32'h5553_4C56)) dut0 (
    .clk_i       (clk),
    .rst_i       (rst_s[0]),
    .mem_valid_i (valid_s[0]),
    .mem_addr_i  (addr_s[0]),
    .mem_wdata_i (wdata_s[0]),
    .mem_wstrb_i (wstrb_s[0]),
    .mem_rdata_o (rdata0),
    .mem_ready_o (ready0),
    .irq_o       (irq0)
  );

  user_slv_design #(.WAIT_CYCLES(3), .ID_VALUE(32'h5553_4C56)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst_s[1]),
    .mem_valid_i (valid_s[1]),
    .mem_addr_i  (addr_s[1]),
    .mem_wdata_i (wdata_s[1]),
    .mem_wstrb_i (wstrb_s[1]),
    .mem_rdata_o (rdata1),
    .mem_ready_o (ready1),
    .irq_o       (irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors: pop the expected response whenever a DUT presents ready
  always @(negedge clk) begin
    if (ready0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_ready: got ready=1 rdata=%h, required no ready", rdata0);
      end else begin
        e0 = q0.pop_front();
        if (e0.chk) begin
          total++;
          if (rdata0 !== e0.data) begin
            bad++;
            $display("FAIL dut0_rdata addr=%h: got %h required %h", e0.addr, rdata0, e0.data);
          end
        end
        $display("dut0 xfer addr=%h rdata=%h", e0.addr, rdata0);
      end
    end
  end

  always @(negedge clk) begin
    if (ready1) begin
      rdy1_cnt++;
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_ready: got ready=1 rdata=%h, required no ready", rdata1);
      end else begin
        e1 = q1.pop_front();
        if (e1.chk) begin
          total++;
          if (rdata1 !== e1.data) begin
            bad++;
            $display("FAIL dut1_rdata addr=%h: got %h required %h", e1.addr, rdata1, e1.data);
          end
        end
        $display("dut1 xfer addr=%h rdata=%h", e1.addr, rdata1);
      end
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ready0 : ready1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Issue one transaction; exp_rd is the value the read path must return
  task automatic xfer(input int sel, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] exp_rd, input logic chk);
    exp_t e;
    int   waited;
    logic seen;
    @(negedge clk);
    e.addr = a; e.data = exp_rd; e.chk = chk;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    valid_s[sel] = 1'b1; addr_s[sel] = a; wdata_s[sel] = wd; wstrb_s[sel] = ws;
    waited = 0; seen = 1'b0;
    while (!seen && waited < 30) begin
      @(negedge clk);
      waited++;
      if (rdy(sel)) seen = 1'b1;
    end
    total++;
    if (!seen || waited != ((sel == 0) ? 2 : 4)) begin
      bad++;
      $display("FAIL latency dut%0d addr=%h: got %0d cycles (seen=%0d) required %0d",
               sel, a, waited, seen, (sel == 0) ? 2 : 4);
    end
    @(posedge clk);
    #1;
    valid_s[sel] = 1'b0; wstrb_s[sel] = 4'h0;
  endtask

  int base;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; valid_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0; wstrb_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    @(negedge clk);
    check("reset_ready0", {31'd0, ready0}, 32'd0);
    check("reset_rdata0", rdata0, 32'd0);
    check("reset_irq0",   {31'd0, irq0},   32'd0);
    check("reset_ready1", {31'd0, ready1}, 32'd0);

    // Register reset values and ID
    xfer(0, 32'h00, 32'h0, 4'h0, 32'h5553_4C56, 1'b1);
    xfer(0, 32'h04, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    xfer(0, 32'h0C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1);
    xfer(0, 32'h10, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    xfer(0, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    // Byte-masked SCR, write returns pre-write value
    xfer(0, 32'h14, 32'h1234_5678, 4'b1100, 32'h0000_0000, 1'b1);
    xfer(0, 32'h14, 32'h0, 4'h0, 32'h1234_0000, 1'b1);
    // Scratch RAM
    xfer(0, 32'h48, 32'h0000_0000, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h48, 32'hA5A5_A5A5, 4'b0101, 32'h0000_0000, 1'b1);
    xfer(0, 32'h48, 32'h0, 4'h0, 32'h00A5_00A5, 1'b1);
    xfer(0, 32'h7C, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h7C, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
    xfer(0, 32'h48, 32'h0, 4'h0, 32'h00A5_00A5, 1'b1);
    // Unmapped offsets
    xfer(0, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xfer(0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 32'hFC, 32'h0, 4'h0, 32'h0, 1'b1);

    // One-shot timer: CMP=5, EN|IE
    xfer(0, 32'h0C, 32'h0000_0005, 4'hF, 32'hFFFF_FFFF, 1'b1);
    xfer(0, 32'h04, 32'h0000_0003, 4'hF, 32'h0000_0000, 1'b1);
    repeat (7) @(negedge clk);
    check("irq_before_lag", {31'd0, irq0}, 32'd0);
    @(negedge clk);
    check("irq_after_exp", {31'd0, irq0}, 32'd1);
    xfer(0, 32'h10, 32'h0, 4'h0, 32'h0000_0005, 1'b1);
    xfer(0, 32'h04, 32'h0, 4'h0, 32'h0000_0002, 1'b1);
    xfer(0, 32'h08, 32'h0, 4'h0, 32'h0000_0001, 1'b1);
    xfer(0, 32'h08, 32'h1, 4'h1, 32'h0000_0001, 1'b1);
    xfer(0, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    @(negedge clk);
    check("irq_after_w1c", {31'd0, irq0}, 32'd0);

    // Auto-reload every 4 cycles; W1C lands on an expiry edge
    xfer(0, 32'h0C, 32'h0000_0003, 4'hF, 32'h0000_0005, 1'b1);
    xfer(0, 32'h04, 32'h0000_000D, 4'hF, 32'h0000_0002, 1'b1);
    @(negedge clk);
    xfer(0, 32'h08, 32'h1, 4'h1, 32'h0000_0000, 1'b1);
    xfer(0, 32'h08, 32'h1, 4'h1, 32'h0000_0001, 1'b1);
    xfer(0, 32'h08, 32'h0, 4'h0, 32'h0000_0001, 1'b1);
    xfer(0, 32'h10, 32'h0, 4'h0, 32'h0000_0003, 1'b1);
    xfer(0, 32'h04, 32'h0, 4'hF, 32'h0000_0005, 1'b1);

    // dut1: abort during WAIT leaves SCR untouched
    xfer(1, 32'h14, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b1);
    @(negedge clk);
    base = rdy1_cnt;
    valid_s[1] = 1'b1; addr_s[1] = 32'h14; wdata_s[1] = 32'hCAFE_F00D; wstrb_s[1] = 4'hF;
    repeat (2) @(negedge clk);
    valid_s[1] = 1'b0; wstrb_s[1] = 4'h0;
    repeat (8) @(negedge clk);
    check("abort_no_ready", rdy1_cnt, base);
    xfer(1, 32'h14, 32'h0, 4'h0, 32'h1122_3344, 1'b1);
    xfer(1, 32'hFC, 32'h0, 4'h0, 32'h0000_0000, 1'b1);

    // dut1: reset during WAIT
    xfer(1, 32'h0C, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF, 1'b1);
    xfer(1, 32'h04, 32'h0000_0007, 4'hF, 32'h0000_0000, 1'b1);
    @(negedge clk);
    base = rdy1_cnt;
    valid_s[1] = 1'b1; addr_s[1] = 32'h14; wdata_s[1] = 32'h0; wstrb_s[1] = 4'hF;
    repeat (2) @(negedge clk);
    rst_s[1] = 1'b1;
    @(negedge clk);
    rst_s[1] = 1'b0; valid_s[1] = 1'b0; wstrb_s[1] = 4'h0;
    check("rst_irq1", {31'd0, irq1}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    repeat (6) @(negedge clk);
    check("rst_no_ready", rdy1_cnt, base);
    xfer(1, 32'h04, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    xfer(1, 32'h14, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    xfer(1, 32'h0C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1);
    xfer(1, 32'h10, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    xfer(1, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 1'b1);

    repeat (5) @(negedge clk);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
